// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue sequencer.
//   - 4-bit ALU opcode encodings (OP_NAND .. OP_FUNC)
//   - is_arith(): opcodes that write the architectural carry flag
//   - is_legal(): opcodes the ALU implements
//   - alu_state_e: sequencer FSM encoding (IDLE/DRIVE/HOLD, 2-bit)
//   - alu_req_t: queued request payload {a, b, op, cin, use_cf}, 14 bits
package alu_pkg;

  localparam logic [3:0] OP_NAND = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_LSR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADDC = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_FUNC = 4'b1111;

  localparam int REQ_W = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic       cin;
    logic       use_cf;
  } alu_req_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_NAND, OP_NOR, OP_XOR, OP_NOT, OP_LSR,
      OP_ADD, OP_ADDC, OP_SUB, OP_FUNC: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: request queue in front of the ALU issue sequencer.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the queue)
//   push_i, data_i   write request; ignored while full (no pass-through)
//   pop_i, data_o    read request; data_o is the head entry, valid when !empty_o
//   full_o, empty_o  occupancy status
// Simultaneous push and pop on a partly filled queue both take effect.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue stage for the 4-bit combinational ALU.
// Requests are queued, popped one at a time into registers that drive the
// ALU pins, and the settled ALU outputs are captured into a result register.
// An architectural carry flag is written by ADD/ADDC/SUB so multi-nibble
// add-with-carry chains can pass carry between requests.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready, in_*          request input (a, b, op, cin, use_cf)
//   alu_a/alu_b/alu_op/alu_cin       registered ALU input pins
//   alu_s/alu_cout/alu_of            combinational ALU outputs
//   res_valid/res_ready, res_*       captured result output
//   carry_flag                       current architectural carry flag
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready depends only on queue occupancy (and reset), never on
// in_valid; res_valid, once raised, stays high with res_* stable until the
// edge where res_ready is seen.
//
// Build option ALU_OPCHECK_EN: illegal opcodes are popped but issued to the
// ALU as 0000, and their result is forced to zero with res_err=1. Without
// it opcodes pass through unchanged and res_err stays 0.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_op,
  input  logic       in_cin,
  input  logic       in_use_cf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_s,
  input  logic       alu_cout,
  input  logic       alu_of,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_s,
  output logic       res_cout,
  output logic       res_of,
  output logic       res_err,
  output logic       carry_flag
);

  alu_state_e state_q, state_d;

  logic [REQ_W-1:0] push_data, head_data;
  alu_req_t         head;
  logic             fifo_full, fifo_empty;
  logic             pop, capture, consume;
  logic             pop_illegal;
  logic [3:0]       pop_op;

  logic [3:0] alu_a_q, alu_b_q, alu_op_q;
  logic       alu_cin_q, err_q;
  logic [3:0] res_s_q;
  logic       res_cout_q, res_of_q, res_err_q, res_valid_q;
  logic       cf_q;

  assign push_data = {in_a, in_b, in_op, in_cin, in_use_cf};
  assign head      = alu_req_t'(head_data);

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Held low while rst is asserted so nothing is accepted during reset.
  assign in_ready = !fifo_full && !rst;

`ifdef ALU_OPCHECK_EN
  assign pop_illegal = !is_legal(head.op);
  assign pop_op      = pop_illegal ? OP_NAND : head.op;
`else
  assign pop_illegal = 1'b0;
  assign pop_op      = head.op;
`endif

  // FSM: next state and control strobes.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          consume = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      err_q       <= 1'b0;
      res_s_q     <= '0;
      res_cout_q  <= 1'b0;
      res_of_q    <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cf_q        <= 1'b0;
    end else begin
      if (pop) begin
        alu_a_q   <= head.a;
        alu_b_q   <= head.b;
        alu_op_q  <= pop_op;
        // The flag is read at pop time; a capture always lands at least one
        // edge before the next pop, so a chained ADDC sees its predecessor.
        alu_cin_q <= head.use_cf ? cf_q : head.cin;
        err_q     <= pop_illegal;
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        if (err_q) begin
          res_s_q    <= '0;
          res_cout_q <= 1'b0;
          res_of_q   <= 1'b0;
          res_err_q  <= 1'b1;
        end else begin
          res_s_q    <= alu_s;
          res_cout_q <= alu_cout;
          res_of_q   <= alu_of;
          res_err_q  <= 1'b0;
          if (is_arith(alu_op_q)) cf_q <= alu_cout;
        end
      end else if (consume) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_cin    = alu_cin_q;
  assign res_valid  = res_valid_q;
  assign res_s      = res_s_q;
  assign res_cout   = res_cout_q;
  assign res_of     = res_of_q;
  assign res_err    = res_err_q;
  assign carry_flag = cf_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural model of the 4-bit ALU
// hooked to the alu_* pins. Honours ALU_OPCHECK_EN the same way as the RTL.
module tb_alu_issue_seq;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b, in_op;
  logic       in_cin, in_use_cf;
  logic [3:0] alu_a, alu_b, alu_op;
  logic       alu_cin;
  logic [3:0] alu_s;
  logic       alu_cout, alu_of;
  logic       res_valid, res_ready;
  logic [3:0] res_s;
  logic       res_cout, res_of, res_err, carry_flag;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  alu_issue_seq #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_cin     (in_cin),
    .in_use_cf  (in_use_cf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_s      (alu_s),
    .alu_cout   (alu_cout),
    .alu_of     (alu_of),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_cout   (res_cout),
    .res_of     (res_of),
    .res_err    (res_err),
    .carry_flag (carry_flag)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU
  logic [4:0] m_sum;
  always_comb begin
    m_sum    = '0;
    alu_s    = '0;
    alu_cout = 1'b0;
    alu_of   = 1'b0;
    case (alu_op)
      4'b0000: alu_s = ~(alu_a & alu_b);
      4'b0001: alu_s = ~(alu_a | alu_b);
      4'b0010: alu_s = alu_a ^ alu_b;
      4'b0100: alu_s = ~alu_a;
      4'b0101: begin alu_s = alu_a >> 1; alu_cout = alu_a[0]; end
      4'b1000, 4'b1001: begin
        m_sum    = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_op == 4'b1001) ? {4'b0, alu_cin} : 5'd0);
        alu_s    = m_sum[3:0];
        alu_cout = m_sum[4];
        alu_of   = (alu_a[3] == alu_b[3]) && (m_sum[3] != alu_a[3]);
      end
      4'b1010: begin
        m_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_s    = m_sum[3:0];
        alu_cout = m_sum[4];
        alu_of   = (alu_a[3] != alu_b[3]) && (m_sum[3] != alu_a[3]);
      end
      4'b1111: alu_s = alu_a & alu_b;
      default: begin alu_s = 4'b0101; alu_cout = 1'b1; alu_of = 1'b1; end
    endcase
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                      input logic cin, input logic use_cf);
    int n = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_cin    = cin;
    in_use_cf = use_cf;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("push_ready", 8'(in_ready), 8'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 8'(res_valid), 8'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_cin = 1'b0; in_use_cf = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  8'(in_ready),   8'd0);
    chk("rst_res_valid", 8'(res_valid),  8'd0);
    chk("rst_carry",     8'(carry_flag), 8'd0);
    chk("rst_alu_a",     8'(alu_a),      8'd0);
    chk("rst_res_s",     8'(res_s),      8'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 8'(in_ready), 8'd1);

    // ADD 0110+0011, exact latency: accept in cycle 0, result in cycle 3
    push(4'b0110, 4'b0011, 4'b1000, 1'b0, 1'b0);
    chk("add_c1_valid", 8'(res_valid), 8'd0);
    tick();
    chk("add_alu_a",    8'(alu_a),     8'h6);
    chk("add_alu_b",    8'(alu_b),     8'h3);
    chk("add_alu_op",   8'(alu_op),    8'h8);
    chk("add_c2_valid", 8'(res_valid), 8'd0);
    tick();
    chk("add_c3_valid", 8'(res_valid), 8'd1);
    chk("add_s",        8'(res_s),     8'h9);
    chk("add_cout",     8'(res_cout),  8'd0);
    chk("add_of",       8'(res_of),    8'd1);
    chk("add_err",      8'(res_err),   8'd0);
    chk("add_carry",    8'(carry_flag), 8'd0);
    tick();
    chk("add_hold_stable", 8'(res_s), 8'h9);
    consume();
    chk("add_consumed", 8'(res_valid), 8'd0);

    // Carry chain: ADD 0111+1001 then ADDC 0001+0001 using the flag
    push(4'b0111, 4'b1001, 4'b1000, 1'b0, 1'b0);
    push(4'b0001, 4'b0001, 4'b1001, 1'b0, 1'b1);
    wait_valid("chain1_valid");
    chk("chain1_s",     8'(res_s),      8'h0);
    chk("chain1_cout",  8'(res_cout),   8'd1);
    chk("chain1_carry", 8'(carry_flag), 8'd1);
    consume();
    chk("chain2_alu_cin", 8'(alu_cin),   8'd1);
    chk("chain2_alu_op",  8'(alu_op),    8'h9);
    chk("chain2_drive",   8'(res_valid), 8'd0);
    tick();
    chk("chain2_valid", 8'(res_valid),  8'd1);
    chk("chain2_s",     8'(res_s),      8'h3);
    chk("chain2_cout",  8'(res_cout),   8'd0);
    chk("chain2_carry", 8'(carry_flag), 8'd0);
    consume();

    // SUB 0111-0101 (sets carry flag: no borrow), then NOT leaves it alone
    push(4'b0111, 4'b0101, 4'b1010, 1'b0, 1'b0);
    wait_valid("sub_valid");
    chk("sub_s",     8'(res_s),      8'h2);
    chk("sub_of",    8'(res_of),     8'd0);
    chk("sub_carry", 8'(carry_flag), 8'd1);
    consume();
    push(4'b1101, 4'b0000, 4'b0100, 1'b0, 1'b0);
    wait_valid("not_valid");
    chk("not_s",     8'(res_s),      8'h2);
    chk("not_carry", 8'(carry_flag), 8'd1);
    consume();

    // Backpressure: 6 back-to-back pushes, only 5 fit
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 4'(i); in_b = 4'b1010; in_op = 4'b0010;
      in_cin = 1'b0; in_use_cf = 1'b0;
      chk($sformatf("bp_in_ready%0d", i), 8'(in_ready), (i < 5) ? 8'd1 : 8'd0);
      if (i < 5) exp_q.push_back(4'(i) ^ 4'b1010);
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_valid("bp_first_valid");
    while (exp_q.size() != 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      chk("bp_valid", 8'(res_valid), 8'd1);
      chk("bp_s",     8'(res_s),     8'(e));
      tick();
      chk("bp_gap",   8'(res_valid), 8'd0);
      tick();
    end
    res_ready = 1'b0;
    chk("bp_drained", 8'(res_valid), 8'd0);
    chk("bp_ready",   8'(in_ready),  8'd1);

    // Reset while holding a result with 3 queued behind it
    for (int i = 0; i < 4; i++) push(4'(i), 4'b0000, 4'b0010, 1'b0, 1'b0);
    chk("rm_hold_valid", 8'(res_valid),  8'd1);
    chk("rm_carry_pre",  8'(carry_flag), 8'd1);
    rst = 1'b1;
    tick();
    chk("rm_in_ready_rst", 8'(in_ready),   8'd0);
    chk("rm_valid_rst",    8'(res_valid),  8'd0);
    chk("rm_carry_rst",    8'(carry_flag), 8'd0);
    rst = 1'b0;
    tick();
    chk("rm_in_ready", 8'(in_ready), 8'd1);
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rm_no_stale", 8'(res_valid), 8'd0);
      tick();
    end
    res_ready = 1'b0;

    // Opcode check: set the flag, then issue illegal op 0011
    push(4'b1111, 4'b0001, 4'b1000, 1'b0, 1'b0);
    wait_valid("oc_setup_valid");
    chk("oc_setup_carry", 8'(carry_flag), 8'd1);
    consume();
    push(4'b1111, 4'b1111, 4'b0011, 1'b0, 1'b0);
    wait_valid("oc_valid");
`ifdef ALU_OPCHECK_EN
    chk("oc_alu_op", 8'(alu_op),   8'h0);
    chk("oc_err",    8'(res_err),  8'd1);
    chk("oc_s",      8'(res_s),    8'h0);
    chk("oc_cout",   8'(res_cout), 8'd0);
    chk("oc_of",     8'(res_of),   8'd0);
`else
    chk("oc_alu_op", 8'(alu_op),   8'h3);
    chk("oc_err",    8'(res_err),  8'd0);
    chk("oc_s",      8'(res_s),    8'h5);
    chk("oc_cout",   8'(res_cout), 8'd1);
`endif
    chk("oc_carry", 8'(carry_flag), 8'd1);
    consume();
    push(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
    wait_valid("nor_valid");
    chk("nor_s",   8'(res_s),   8'hF);
    chk("nor_err", 8'(res_err), 8'd0);
    consume();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
